// File: rtl/noekeon_round_const_seq.sv
// NOEKEON round-constant sequencer: emits NR+1 constants in encrypt or decrypt order.
// Optional build macro NOEKEON_RC_RESTART_EN lets inStart restart a running sequence.
module noekeon_round_const_seq #(
  parameter int NR = 16
) (
  input  logic       inClk,
  input  logic       inRstN,
  input  logic       inStart,
  input  logic       inDecrypt,
  input  logic       inNext,
  output logic [7:0] outRoundConst,
  output logic [4:0] outRoundNum,
  output logic       outValid,
  output logic       outLast,
  output logic       outDone,
  output logic       outState
);

  // Handshake: a constant is offered while outValid is high; the consumer
  // pulses inNext in any cycle it has taken it, and the block advances on
  // that clock edge. Without inNext everything holds indefinitely.

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [7:0] ENC_START = 8'h80;
  localparam logic [4:0] LAST_NUM  = 5'(NR);

`ifdef NOEKEON_RC_RESTART_EN
  localparam bit RESTART_EN = 1'b1;
`else
  localparam bit RESTART_EN = 1'b0;
`endif

  function automatic logic [7:0] enc_step(input logic [7:0] c);
    return {c[6:0], 1'b0} ^ (c[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] dec_step(input logic [7:0] c);
    logic [7:0] x;
    x = c ^ 8'h1B;
    return c[0] ? {1'b1, x[7:1]} : {1'b0, c[7:1]};
  endfunction

  // Evaluated at elaboration only, so the decrypt start costs no run-time iteration.
  function automatic logic [7:0] fwd_const(input int k);
    logic [7:0] c;
    c = ENC_START;
    for (int i = 0; i < k; i++) c = enc_step(c);
    return c;
  endfunction

  localparam logic [7:0] DEC_START = fwd_const(NR);

  if (NR < 1 || NR > 31) begin : g_nr_range
    $error("noekeon_round_const_seq: NR must be in 1..31");
  end

  state_t     state;
  logic [7:0] rc;
  logic [4:0] num;
  logic       dir;
  logic       done;
  logic [7:0] start_val;

  assign start_val = inDecrypt ? DEC_START : ENC_START;

  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      state <= IDLE;
      rc    <= 8'h00;
      num   <= 5'd0;
      dir   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (inStart) begin
            state <= RUN;
            num   <= 5'd0;
            dir   <= inDecrypt;
            rc    <= start_val;
          end
        end
        RUN: begin
          if (RESTART_EN && inStart) begin
            num <= 5'd0;
            dir <= inDecrypt;
            rc  <= start_val;
          end else if (inNext) begin
            if (num == LAST_NUM) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              num <= num + 5'd1;
              rc  <= dir ? dec_step(rc) : enc_step(rc);
            end
          end
        end
      endcase
    end
  end

  assign outRoundConst = rc;
  assign outRoundNum   = num;
  assign outValid      = (state == RUN);
  assign outLast       = (state == RUN) && (num == LAST_NUM);
  assign outDone       = done;
  assign outState      = state;

  a_num_bound : assert property (@(posedge inClk) disable iff (!inRstN) num <= LAST_NUM);
  a_done_idle : assert property (@(posedge inClk) disable iff (!inRstN) done |-> state == IDLE);

endmodule

// File: tb/tb_noekeon_round_const_seq.sv
// Bench for noekeon_round_const_seq: NR=16 and NR=4 instances share stimulus;
// vector table, hand corner sequences and a random run against a reference model.
module tb_noekeon_round_const_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       decrypt = 1'b0;
  logic       nxt = 1'b0;

  logic [7:0] rc16, rc4;
  logic [4:0] num16, num4;
  logic       valid16, last16, done16, st16;
  logic       valid4, last4, done4, st4;

  int n_checks = 0;
  int n_fail = 0;

`ifdef NOEKEON_RC_RESTART_EN
  localparam bit RESTART = 1'b1;
`else
  localparam bit RESTART = 1'b0;
`endif

  noekeon_round_const_seq #(.NR(16)) dut16 (
    .inClk(clk), .inRstN(rst_n), .inStart(start), .inDecrypt(decrypt), .inNext(nxt),
    .outRoundConst(rc16), .outRoundNum(num16), .outValid(valid16), .outLast(last16),
    .outDone(done16), .outState(st16)
  );

  noekeon_round_const_seq #(.NR(4)) dut4 (
    .inClk(clk), .inRstN(rst_n), .inStart(start), .inDecrypt(decrypt), .inNext(nxt),
    .outRoundConst(rc4), .outRoundNum(num4), .outValid(valid4), .outLast(last4),
    .outDone(done4), .outState(st4)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    bit started;
    bit active;
    bit dir;
    bit done;
    int idx;
  } model_t;

  model_t m16, m4;

  // k-th forward constant: repeated multiplication by x in GF(2^8) mod 0x11B.
  function automatic int fwd(int k);
    int c;
    c = 128;
    for (int i = 0; i < k; i++) begin
      c = c * 2;
      if (c > 255) c = c ^ 283;
    end
    return c;
  endfunction

  function automatic model_t mreset();
    model_t r;
    r.started = 0; r.active = 0; r.dir = 0; r.done = 0; r.idx = 0;
    return r;
  endfunction

  function automatic model_t mstep(model_t m, bit s, bit d, bit n, int nr);
    model_t r;
    r = m;
    r.done = 0;
    if (!m.active) begin
      if (s) begin
        r.active = 1; r.started = 1; r.idx = 0; r.dir = d;
      end
    end else if (RESTART && s) begin
      r.idx = 0; r.dir = d;
    end else if (n) begin
      if (m.idx == nr) begin
        r.active = 0; r.done = 1;
      end else begin
        r.idx = m.idx + 1;
      end
    end
    return r;
  endfunction

  function automatic int mrc(model_t m, int nr);
    if (!m.started) return 0;
    return m.dir ? fwd(nr - m.idx) : fwd(m.idx);
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check16(input string tag);
    chk({tag, ".rc16"}, 32'(rc16), 32'(mrc(m16, 16)));
    chk({tag, ".num16"}, 32'(num16), 32'(m16.idx));
    chk({tag, ".valid16"}, 32'(valid16), 32'(m16.active));
    chk({tag, ".last16"}, 32'(last16), 32'(m16.active && m16.idx == 16));
    chk({tag, ".done16"}, 32'(done16), 32'(m16.done));
    chk({tag, ".st16"}, 32'(st16), 32'(m16.active));
  endtask

  task automatic check4(input string tag);
    chk({tag, ".rc4"}, 32'(rc4), 32'(mrc(m4, 4)));
    chk({tag, ".num4"}, 32'(num4), 32'(m4.idx));
    chk({tag, ".valid4"}, 32'(valid4), 32'(m4.active));
    chk({tag, ".last4"}, 32'(last4), 32'(m4.active && m4.idx == 4));
    chk({tag, ".done4"}, 32'(done4), 32'(m4.done));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".rc16"}, 32'(rc16), 32'h0);
    chk({tag, ".num16"}, 32'(num16), 32'h0);
    chk({tag, ".valid16"}, 32'(valid16), 32'h0);
    chk({tag, ".last16"}, 32'(last16), 32'h0);
    chk({tag, ".done16"}, 32'(done16), 32'h0);
    chk({tag, ".rc4"}, 32'(rc4), 32'h0);
    chk({tag, ".valid4"}, 32'(valid4), 32'h0);
  endtask

  // ---------------- driver tasks ----------------
  // Called at posedge+1: drive, advance one edge, settle, advance models.
  task automatic cyc(input bit s, input bit d, input bit n);
    start = s; decrypt = d; nxt = n;
    @(posedge clk);
    #1;
    m16 = mstep(m16, s, d, n, 16);
    m4  = mstep(m4, s, d, n, 4);
  endtask

  task automatic rst_pulse(input string tag, input bit do_check);
    rst_n = 1'b0;
    #1;
    m16 = mreset();
    m4  = mreset();
    if (do_check) check_reset_vals({tag, ".async"});
    start = 1'b0; nxt = 1'b1; decrypt = 1'b1;
    @(posedge clk);
    #1;
    if (do_check) check_reset_vals({tag, ".held"});
    rst_n = 1'b1;
    nxt = 1'b0; decrypt = 1'b0;
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 0;
    while ((valid16 || valid4) && budget < 40) begin
      cyc(1'b0, 1'b0, 1'b1);
      budget++;
    end
    chk({tag, ".drain_timeout"}, 32'(valid16 || valid4), 32'h0);
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit         s;
    bit         d;
    bit         n;
    logic [7:0] rc;
    logic [4:0] num;
    bit         valid;
    bit         last;
    bit         done;
  } vec_t;

  vec_t vecs[$];
  logic [7:0] enc_tbl [0:16] = '{8'h80, 8'h1B, 8'h36, 8'h6C, 8'hD8, 8'hAB, 8'h4D, 8'h9A,
                                 8'h2F, 8'h5E, 8'hBC, 8'h63, 8'hC6, 8'h97, 8'h35, 8'h6A, 8'hD4};
  logic [7:0] enc4_tbl [0:4] = '{8'h80, 8'h1B, 8'h36, 8'h6C, 8'hD8};

  initial begin
    m16 = mreset();
    m4  = mreset();

    // clock/reset block
    #2 rst_n = 1'b0;
    #1 check_reset_vals("reset");
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    cyc(1'b0, 1'b1, 1'b1);
    check16("idle_after_reset");

    // Encrypt run (start with simultaneous next), back-to-back decrypt run, idle next.
    vecs.push_back('{1, 0, 1, enc_tbl[0], 5'd0, 1, 0, 0});
    for (int i = 1; i <= 16; i++)
      vecs.push_back('{0, 1, 1, enc_tbl[i], 5'(i), 1, i == 16, 0});
    vecs.push_back('{0, 0, 1, enc_tbl[16], 5'd16, 0, 0, 1});
    vecs.push_back('{1, 1, 1, enc_tbl[16], 5'd0, 1, 0, 0});
    for (int i = 1; i <= 16; i++)
      vecs.push_back('{0, 0, 1, enc_tbl[16-i], 5'(i), 1, i == 16, 0});
    vecs.push_back('{0, 0, 1, enc_tbl[0], 5'd16, 0, 0, 1});
    vecs.push_back('{0, 1, 1, enc_tbl[0], 5'd16, 0, 0, 0});

    foreach (vecs[k]) begin
      string t;
      t = $sformatf("tbl%0d", k);
      cyc(vecs[k].s, vecs[k].d, vecs[k].n);
      chk({t, ".rc"}, 32'(rc16), 32'(vecs[k].rc));
      chk({t, ".num"}, 32'(num16), 32'(vecs[k].num));
      chk({t, ".valid"}, 32'(valid16), 32'(vecs[k].valid));
      chk({t, ".last"}, 32'(last16), 32'(vecs[k].last));
      chk({t, ".done"}, 32'(done16), 32'(vecs[k].done));
      check4(t);
    end
    drain("after_tbl");

    // Next withheld for 5 cycles at num 3.
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 1'b0);
      chk($sformatf("hold%0d.rc", i), 32'(rc16), 32'h6C);
      chk($sformatf("hold%0d.valid", i), 32'(valid16), 32'h1);
      chk($sformatf("hold%0d.num", i), 32'(num16), 32'd3);
    end
    cyc(1'b0, 1'b0, 1'b1);
    chk("hold_release.rc", 32'(rc16), 32'hD8);
    check16("hold_release");
    drain("after_hold");

    // Reset mid-run at num 7.
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 1'b1);
    chk("pre_reset.num", 32'(num16), 32'd7);
    rst_pulse("mid_reset", 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b1);
      chk($sformatf("post_reset%0d.done", i), 32'(done16), 32'h0);
      check16($sformatf("post_reset%0d", i));
    end
    cyc(1'b1, 1'b0, 1'b0);
    chk("restart_after_reset.rc", 32'(rc16), 32'h80);
    chk("restart_after_reset.num", 32'(num16), 32'd0);
    drain("after_reset");

    // Start in RUN with decrypt and next at num 5.
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1);
    chk("pre_restart.rc", 32'(rc16), 32'hAB);
    cyc(1'b1, 1'b1, 1'b1);
    chk("run_start.rc", 32'(rc16), RESTART ? 32'hD4 : 32'h4D);
    chk("run_start.num", 32'(num16), RESTART ? 32'd0 : 32'd6);
    chk("run_start.done", 32'(done16), 32'h0);
    check16("run_start");
    drain("after_run_start");

    // NR=4 explicit sequences.
    for (int dir = 0; dir < 2; dir++) begin
      cyc(1'b1, 1'(dir), 1'b0);
      for (int i = 0; i <= 4; i++) begin
        chk($sformatf("nr4_d%0d_%0d.rc", dir, i), 32'(rc4), 32'(dir ? enc4_tbl[4-i] : enc4_tbl[i]));
        chk($sformatf("nr4_d%0d_%0d.last", dir, i), 32'(last4), 32'(i == 4));
        cyc(1'b0, 1'b0, 1'b1);
      end
      chk($sformatf("nr4_d%0d.done", dir), 32'(done4), 32'h1);
      chk($sformatf("nr4_d%0d.valid", dir), 32'(valid4), 32'h0);
      drain($sformatf("nr4_d%0d", dir));
    end

    // Random stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst_pulse("rand_rst", 1'b0);
        check16($sformatf("rand_rst%0d", i));
        check4($sformatf("rand_rst%0d", i));
      end else begin
        cyc($urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 2) != 0);
        check16($sformatf("rand%0d", i));
        check4($sformatf("rand%0d", i));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/noekeon_round_const_seq.md
NOEKEON_ROUND_CONST_SEQ -- requirements
Module: noekeon_round_const_seq

Interface
REQ-001 Parameter NR, default 16, number of cipher rounds; the sequence is NR+1 constants; legal range 1..31.
REQ-002 inClk  input  1  single clock; all state updates on its rising edge.
REQ-003 inRstN  input  1  reset, asynchronous assert, active-low.
REQ-004 inStart  input  1  one-cycle request to begin a constant sequence.
REQ-005 inDecrypt  input  1  direction, sampled only with an accepted inStart: 0 = encrypt order, 1 = decrypt order.
REQ-006 inNext  input  1  consumer has used the current constant; advance.
REQ-007 outRoundConst  output  8  current round constant.
REQ-008 outRoundNum  output  5  index of current constant within the sequence, 0..NR.
REQ-009 outValid  output  1  outRoundConst/outRoundNum are meaningful.
REQ-010 outLast  output  1  high while outValid and outRoundNum == NR.
REQ-011 outDone  output  1  one-cycle pulse after the last constant is consumed.

Function
REQ-012 The block SHALL have two states: IDLE and RUN; outValid SHALL equal (state == RUN).
REQ-013 IDLE + inStart: next cycle RUN, outRoundNum = 0, direction latched; outRoundConst = 8'h80 (encrypt) or the NR-th forward constant (decrypt; 8'hD4 for NR = 16).
REQ-014 Encrypt step: next = {c[6:0],1'b0} XOR (c[7] ? 8'h1B : 8'h00); for NR = 16: 80,1B,36,6C,D8,AB,4D,9A,2F,5E,BC,63,C6,97,35,6A,D4.
REQ-015 Decrypt step: next = c[0] ? ({1'b1,(c XOR 8'h1B)[7:1]}) : {1'b0,c[7:1]}; the decrypt sequence SHALL be exactly the encrypt sequence reversed, ending at 8'h80.
REQ-016 The decrypt start value for NR SHALL be produced by a reset-independent constant function/table, not by iterating at run time; latency start->first constant is exactly 1 cycle for any NR.
REQ-017 RUN + inNext + outRoundNum < NR: next cycle outRoundConst steps per latched direction, outRoundNum increments by 1; latency exactly 1 cycle.
REQ-018 RUN + no inNext: outRoundConst, outRoundNum, outValid SHALL hold indefinitely.
REQ-019 RUN + inNext + outRoundNum == NR: next cycle IDLE, outValid = 0, outDone = 1 for exactly one cycle; outRoundConst/outRoundNum hold last values.
REQ-020 inNext in IDLE SHALL be ignored; inDecrypt changes outside an accepted inStart SHALL have no effect.
REQ-021 IDLE + inStart + inNext in the same cycle: start accepted, inNext ignored.
REQ-022 inStart on the same cycle outDone is asserted (state IDLE) SHALL be accepted normally (back-to-back sequences, no dead cycle beyond the one IDLE cycle).
REQ-023 outRoundNum SHALL never exceed NR and never wrap.

Reset
REQ-024 While inRstN = 0: state IDLE, outRoundConst = 8'h00, outRoundNum = 0, outValid = 0, outLast = 0, outDone = 0, latched direction = encrypt.
REQ-025 Reset asserted mid-sequence SHALL abort immediately (asynchronously); after release the block waits in IDLE for inStart, no outDone pulse.

Configuration
REQ-026 Macro NOEKEON_RC_RESTART_EN defined: inStart in RUN SHALL restart the sequence (REQ-013 behaviour, new direction latched), overriding a simultaneous inNext; no outDone for the aborted sequence.
REQ-027 NOEKEON_RC_RESTART_EN undefined: inStart in RUN SHALL be ignored and a simultaneous inNext processed per REQ-017/REQ-019.

Verification
REQ-028 NR=16, inStart with inDecrypt=0, inNext every cycle -> outRoundConst 80,1B,...,6A,D4 on 17 consecutive cycles, outLast with D4, outDone one cycle later.
REQ-029 NR=16, inDecrypt=1 start, inNext every cycle -> D4,6A,35,97,...,1B,80, outRoundNum 0..16, outDone after 80 consumed.
REQ-030 Encrypt run, inNext withheld 5 cycles at outRoundNum=3 -> outRoundConst holds 6C, outValid stays 1; next inNext -> D8.
REQ-031 inRstN pulsed low at outRoundNum=7 -> all outputs to reset values within the low period; no outDone; new inStart gives 80 at outRoundNum 0.
REQ-032 inStart with inDecrypt=1 at outRoundNum=5 of encrypt run plus inNext -> with macro: next cycle D4, outRoundNum 0; without: next cycle 4D, outRoundNum 6.
REQ-033 NR=4 encrypt -> 80,1B,36,6C,D8; decrypt -> D8,6C,36,1B,80.
